// File: rtl/wb_qspi_mem_mc.sv
// Wishbone-to-QSPI memory controller for up to four flash/QSPI-RAM devices sharing sck/sd.
// Define WB_QSPI_MEM_MC_CRM_EN to enable flash continuous-read mode (mode byte A5h, EBh skipped).
module wb_qspi_mem_mc #(
  parameter int unsigned NUM_CS = 2,
  parameter logic [NUM_CS-1:0] ROM_MASK = 'b01,
  parameter int unsigned ADR_W = 22,
  parameter int unsigned RD_DUMMY = 4,
  localparam int unsigned SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SEL_W-1:0]  cs_sel_i,
  input  logic              wb_mem_stb_i,
  input  logic              wb_mem_we_i,
  input  logic [3:0]        wb_mem_be_i,
  input  logic [ADR_W-1:0]  wb_mem_adr_i,
  input  logic [31:0]       wb_mem_dat_i,
  output logic              wb_mem_ack_o,
  output logic              wb_mem_err_o,
  output logic [31:0]       wb_mem_dat_o,
  output logic [NUM_CS-1:0] cs_on,
  output logic              sck_o,
  input  logic [3:0]        sd_i,
  output logic [3:0]        sd_o,
  output logic [3:0]        sd_oen_o,
  output logic              busy_o
);

  typedef enum logic [3:0] {
    INIT, IDLE, INSTR, ADDR, MODE, DUMMY, DATA_R, DATA_W, ACK, ERR
  } state_e;

  localparam logic [7:0] INIT_CMD = 8'h35;
  localparam logic [7:0] FLASH_RD = 8'hEB;
  localparam logic [3:0] RAM_DUMMY_LAST = 4'(RD_DUMMY - 1);
  // Flash EBh needs two turnaround cycles on top of the programmed dummy count.
  localparam logic [3:0] FLASH_DUMMY_LAST = 4'(RD_DUMMY + 1);
`ifdef WB_QSPI_MEM_MC_CRM_EN
  localparam logic [7:0] MODE_BYTE = 8'hA5;
`else
  localparam logic [7:0] MODE_BYTE = 8'hFF;
`endif

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [31:0]        wdat_q, wdat_d;
  logic [31:0]        rdat_q, rdat_d;
  logic [NUM_CS-1:0]  csOn_q, csOn_d;
  logic [3:0]         sdO_q, sdO_d;
  logic [3:0]         sdOen_q, sdOen_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
`ifdef WB_QSPI_MEM_MC_CRM_EN
  logic [NUM_CS-1:0]  crm_q, crm_d;
`endif

  logic               romQ, romD, crmHit;
  logic [1:0]         wOff, addrOff, wByte;
  logic [23:0]        byteAddr;
  logic [7:0]         cmdByte;
  logic [3:0]         wrLast;
  logic [NUM_CS-1:0]  selLow;

  function automatic logic [1:0] lowestBe(input logic [3:0] be);
    if (be[0])      return 2'd0;
    else if (be[1]) return 2'd1;
    else if (be[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign romQ     = ROM_MASK[sel_q];
  assign romD     = ROM_MASK[sel_d];
  assign wOff     = lowestBe(be_d);
  assign addrOff  = we_d ? wOff : 2'd0;
  assign byteAddr = 24'({adr_d, addrOff});
  assign wByte    = wOff + cnt_d[2:1];
  assign cmdByte  = we_d ? 8'h38 : 8'h0B;
  assign selLow   = ~(NUM_CS'(1) << sel_d);
  assign wrLast   = (be_q == 4'hF) ? 4'd7 :
                    ((be_q == 4'h3 || be_q == 4'hC) ? 4'd3 : 4'd1);
`ifdef WB_QSPI_MEM_MC_CRM_EN
  assign crmHit   = crm_q[cs_sel_i];
`else
  assign crmHit   = 1'b0;
`endif

  // Sequencing: decide the next phase/index and capture read nibbles during DATA_R.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    sel_d   = sel_q;
    we_d    = we_q;
    be_d    = be_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
`ifdef WB_QSPI_MEM_MC_CRM_EN
    crm_d   = crm_q;
`endif
    case (state_q)
      INIT: begin
        if (cnt_q == 4'd8) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (wb_mem_stb_i) begin
          sel_d  = cs_sel_i;
          we_d   = wb_mem_we_i;
          be_d   = wb_mem_be_i;
          adr_d  = wb_mem_adr_i;
          wdat_d = wb_mem_dat_i;
          if (wb_mem_we_i && ROM_MASK[cs_sel_i])
            state_d = ERR;
          else if (!wb_mem_we_i && ROM_MASK[cs_sel_i] && crmHit)
            state_d = ADDR;
          else
            state_d = INSTR;
        end
      end
      INSTR: begin
        if (cnt_q == (romQ ? 4'd7 : 4'd1)) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        if (cnt_q == 4'd5) begin
          cnt_d = '0;
          if (romQ)      state_d = MODE;
          else if (we_q) state_d = DATA_W;
          else           state_d = DUMMY;
        end
      end
      MODE: begin
        if (cnt_q == 4'd1) begin
          state_d = DUMMY;
          cnt_d   = '0;
        end
      end
      DUMMY: begin
        if (cnt_q == (romQ ? FLASH_DUMMY_LAST : RAM_DUMMY_LAST)) begin
          state_d = DATA_R;
          cnt_d   = '0;
        end
      end
      DATA_R: begin
        rdat_d[{cnt_q[2:1], ~cnt_q[0], 2'b00} +: 4] = sd_i;
        if (cnt_q == 4'd7) begin
          state_d = ACK;
          cnt_d   = '0;
`ifdef WB_QSPI_MEM_MC_CRM_EN
          if (romQ) crm_d[sel_q] = 1'b1;
`endif
        end
      end
      DATA_W: begin
        if (cnt_q == wrLast) begin
          state_d = ACK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin values are derived from the upcoming phase so they are registered with it.
  always_comb begin
    csOn_d  = '1;
    sdO_d   = '0;
    sdOen_d = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_d)
      INIT: begin
        csOn_d  = ROM_MASK;
        sdOen_d = 4'b0001;
        sdO_d   = {3'b000, INIT_CMD[3'(4'd8 - cnt_d)]};
      end
      INSTR: begin
        csOn_d = selLow;
        if (romD) begin
          sdOen_d = 4'b0001;
          sdO_d   = {3'b000, FLASH_RD[~cnt_d[2:0]]};
        end else begin
          sdOen_d = 4'b1111;
          sdO_d   = cnt_d[0] ? cmdByte[3:0] : cmdByte[7:4];
        end
      end
      ADDR: begin
        csOn_d  = selLow;
        sdOen_d = 4'b1111;
        sdO_d   = byteAddr[{3'(3'd5 - cnt_d[2:0]), 2'b00} +: 4];
      end
      MODE: begin
        csOn_d  = selLow;
        sdOen_d = 4'b1111;
        sdO_d   = cnt_d[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
      end
      DUMMY, DATA_R: csOn_d = selLow;
      DATA_W: begin
        csOn_d  = selLow;
        sdOen_d = 4'b1111;
        sdO_d   = wdat_d[{wByte, ~cnt_d[0], 2'b00} +: 4];
      end
      ACK: ack_d = 1'b1;
      ERR: begin
        ack_d = 1'b1;
        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      csOn_q  <= '1;
      sdO_q   <= '0;
      sdOen_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef WB_QSPI_MEM_MC_CRM_EN
      crm_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      be_q    <= be_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      csOn_q  <= csOn_d;
      sdO_q   <= sdO_d;
      sdOen_q <= sdOen_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef WB_QSPI_MEM_MC_CRM_EN
      crm_q   <= crm_d;
`endif
    end
  end

  assign wb_mem_ack_o = ack_q;
  assign wb_mem_err_o = err_q;
  assign wb_mem_dat_o = rdat_q;
  assign cs_on        = csOn_q;
  assign sck_o        = ~clk_i;
  assign sd_o         = sdO_q;
  assign sd_oen_o     = sdOen_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_wb_qspi_mem_mc.sv
// Directed bench for wb_qspi_mem_mc (default parameters); expected values hand-computed.
// Honors WB_QSPI_MEM_MC_CRM_EN for the flash continuous-read expectations.
module tb_wb_qspi_mem_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [0:0]  cs_sel_i;
  logic        wb_mem_stb_i;
  logic        wb_mem_we_i;
  logic [3:0]  wb_mem_be_i;
  logic [21:0] wb_mem_adr_i;
  logic [31:0] wb_mem_dat_i;
  logic        wb_mem_ack_o;
  logic        wb_mem_err_o;
  logic [31:0] wb_mem_dat_o;
  logic [1:0]  cs_on;
  logic        sck_o;
  logic [3:0]  sd_i;
  logic [3:0]  sd_o;
  logic [3:0]  sd_oen_o;
  logic        busy_o;

`ifdef WB_QSPI_MEM_MC_CRM_EN
  localparam int          FL2_ACK     = 23;
  localparam int          FL2_ADDR_AT = 1;
  localparam logic [3:0]  FL2_OEN     = 4'b1111;
  localparam logic [31:0] MODE_EXP    = 32'h000000A5;
`else
  localparam int          FL2_ACK     = 31;
  localparam int          FL2_ADDR_AT = 9;
  localparam logic [3:0]  FL2_OEN     = 4'b0001;
  localparam logic [31:0] MODE_EXP    = 32'h000000FF;
`endif

  wb_qspi_mem_mc dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cs_sel_i     (cs_sel_i),
    .wb_mem_stb_i (wb_mem_stb_i),
    .wb_mem_we_i  (wb_mem_we_i),
    .wb_mem_be_i  (wb_mem_be_i),
    .wb_mem_adr_i (wb_mem_adr_i),
    .wb_mem_dat_i (wb_mem_dat_i),
    .wb_mem_ack_o (wb_mem_ack_o),
    .wb_mem_err_o (wb_mem_err_o),
    .wb_mem_dat_o (wb_mem_dat_o),
    .cs_on        (cs_on),
    .sck_o        (sck_o),
    .sd_i         (sd_i),
    .sd_o         (sd_o),
    .sd_oen_o     (sd_oen_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad = 0;
  logic [3:0]  obsSd  [0:63];
  logic [3:0]  obsOen [0:63];
  logic [1:0]  obsCs  [0:63];
  logic        obsErr [0:63];
  int          ackCycle;
  logic        sawAck;
  logic [1:0]  snapCs;
  logic        snapAck;
  logic        snapBusy;
  logic [3:0]  snapOen;
  logic [31:0] snapDat;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    total++;
    if (obs !== expVal) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expVal);
    end
  endtask

  function automatic logic [31:0] quadVal(input int first, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[27:0], obsSd[first + i]};
    return r;
  endfunction

  function automatic logic [31:0] serialVal(input int first);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[30:0], obsSd[first + i][0]};
    return r;
  endfunction

  // One Wishbone transaction; cycle 0 is the IDLE cycle in which stb is raised.
  task automatic applyStimulus(input logic sel, input logic we, input logic [3:0] be,
                               input logic [21:0] adr, input logic [31:0] wdat,
                               input logic [31:0] rdNibs, input int dataStart, input int abortAt);
    ackCycle = -1;
    sawAck   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      obsSd[i] = '0; obsOen[i] = '0; obsCs[i] = '0; obsErr[i] = 1'b0;
    end
    cs_sel_i     = sel;
    wb_mem_we_i  = we;
    wb_mem_be_i  = be;
    wb_mem_adr_i = adr;
    wb_mem_dat_i = wdat;
    wb_mem_stb_i = 1'b1;
    for (int c = 1; c < 64; c++) begin
      @(posedge clk_i);
      #1;
      if (c == 1) wb_mem_stb_i = 1'b0;
      obsSd[c]  = sd_o;
      obsOen[c] = sd_oen_o;
      obsCs[c]  = cs_on;
      obsErr[c] = wb_mem_err_o;
      if (c >= dataStart && c < dataStart + 8) sd_i = rdNibs[31 - 4 * (c - dataStart) -: 4];
      else sd_i = 4'h0;
      if (abortAt > 0 && c == abortAt) begin
        rst_i = 1'b1;
        #1;
        snapCs   = cs_on;
        snapAck  = wb_mem_ack_o;
        snapBusy = busy_o;
        snapOen  = sd_oen_o;
        snapDat  = wb_mem_dat_o;
      end
      if (wb_mem_ack_o) begin
        sawAck = 1'b1;
        if (ackCycle < 0) ackCycle = c;
      end
      if (abortAt > 0 && c >= abortAt + 3) break;
      if (abortAt == 0 && wb_mem_ack_o) break;
    end
    sd_i = 4'h0;
    if (abortAt == 0) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Called with reset just released; watches the 35h preamble and the return to IDLE.
  task automatic checkInit(input string tag);
    logic [7:0] bits = '0;
    logic       pinsOk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_i);
      #1;
      bits = {bits[6:0], sd_o[0]};
      if (cs_on !== 2'b01 || sd_oen_o !== 4'b0001 || busy_o !== 1'b1) pinsOk = 1'b0;
    end
    checkOutput({tag, "_seq"}, 32'(bits), 32'h35);
    checkOutput({tag, "_pins"}, 32'(pinsOk), 32'h1);
    @(posedge clk_i);
    #1;
    checkOutput({tag, "_idle_busy"}, 32'(busy_o), 32'h0);
    checkOutput({tag, "_idle_cs"}, 32'(cs_on), 32'h3);
  endtask

  initial begin
    rst_i        = 1'b1;
    cs_sel_i     = 1'b0;
    wb_mem_stb_i = 1'b0;
    wb_mem_we_i  = 1'b0;
    wb_mem_be_i  = 4'h0;
    wb_mem_adr_i = '0;
    wb_mem_dat_i = '0;
    sd_i         = 4'h0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_cs", 32'(cs_on), 32'h3);
    checkOutput("rst_oen", 32'(sd_oen_o), 32'h0);
    checkOutput("rst_sdo", 32'(sd_o), 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'h1);
    checkOutput("rst_ack", 32'({wb_mem_ack_o, wb_mem_err_o}), 32'h0);
    checkOutput("rst_dat", wb_mem_dat_o, 32'h0);
    checkOutput("sck", 32'(sck_o), 32'(!clk_i));
    rst_i = 1'b0;
    checkInit("init");

    applyStimulus(1'b1, 1'b0, 4'hF, 22'h000010, 32'h0, 32'h12345678, 13, 0);
    checkOutput("ramrd_instr", quadVal(1, 2), 32'h0B);
    checkOutput("ramrd_addr", quadVal(3, 6), 32'h000040);
    checkOutput("ramrd_oen_instr", 32'(obsOen[1]), 32'hF);
    checkOutput("ramrd_oen_data", 32'(obsOen[13]), 32'h0);
    checkOutput("ramrd_cs", 32'(obsCs[5]), 32'h1);
    checkOutput("ramrd_ack", 32'(ackCycle), 32'd21);
    checkOutput("ramrd_dat", wb_mem_dat_o, 32'h78563412);

    applyStimulus(1'b1, 1'b1, 4'b0100, 22'h000020, 32'h00AB0000, 32'h0, 0, 0);
    checkOutput("ramwr_instr", quadVal(1, 2), 32'h38);
    checkOutput("ramwr_addr", quadVal(3, 6), 32'h000082);
    checkOutput("ramwr_data", quadVal(9, 2), 32'hAB);
    checkOutput("ramwr_cs_data", 32'(obsCs[9]), 32'h1);
    checkOutput("ramwr_ack", 32'(ackCycle), 32'd11);
    checkOutput("ramwr_cs_ack", 32'(obsCs[11]), 32'h3);
    checkOutput("ramwr_err", 32'(obsErr[11]), 32'h0);
    checkOutput("dat_hold", wb_mem_dat_o, 32'h78563412);

    applyStimulus(1'b0, 1'b1, 4'hF, 22'h000005, 32'hDEADBEEF, 32'h0, 0, 0);
    checkOutput("flwr_ack", 32'(ackCycle), 32'd1);
    checkOutput("flwr_err", 32'(obsErr[1]), 32'h1);
    checkOutput("flwr_cs", 32'(obsCs[1]), 32'h3);

    applyStimulus(1'b0, 1'b0, 4'hF, 22'h000100, 32'h0, 32'hCAFE1234, 23, 0);
    checkOutput("flrd1_instr", serialVal(1), 32'hEB);
    checkOutput("flrd1_oen", 32'(obsOen[1]), 32'h1);
    checkOutput("flrd1_addr", quadVal(9, 6), 32'h000400);
    checkOutput("flrd1_mode", quadVal(15, 2), MODE_EXP);
    checkOutput("flrd1_cs", 32'(obsCs[9]), 32'h2);
    checkOutput("flrd1_ack", 32'(ackCycle), 32'd31);
    checkOutput("flrd1_dat", wb_mem_dat_o, 32'h3412FECA);

    applyStimulus(1'b0, 1'b0, 4'hF, 22'h000003, 32'h0, 32'h0F1E2D3C, FL2_ACK - 8, 0);
    checkOutput("flrd2_oen", 32'(obsOen[1]), 32'(FL2_OEN));
    checkOutput("flrd2_addr", quadVal(FL2_ADDR_AT, 6), 32'h00000C);
    checkOutput("flrd2_ack", 32'(ackCycle), 32'(FL2_ACK));
    checkOutput("flrd2_dat", wb_mem_dat_o, 32'h3C2D1E0F);

    applyStimulus(1'b1, 1'b0, 4'hF, 22'h000010, 32'h0, 32'h11111111, 13, 16);
    checkOutput("abort_cs", 32'(snapCs), 32'h3);
    checkOutput("abort_ack", 32'(snapAck), 32'h0);
    checkOutput("abort_busy", 32'(snapBusy), 32'h1);
    checkOutput("abort_oen", 32'(snapOen), 32'h0);
    checkOutput("abort_dat", snapDat, 32'h0);
    checkOutput("abort_noack", 32'(sawAck), 32'h0);
    rst_i = 1'b0;
    checkInit("reinit");

    applyStimulus(1'b1, 1'b0, 4'hF, 22'h000007, 32'h0, 32'h9ABCDEF0, 13, 0);
    checkOutput("post_addr", quadVal(3, 6), 32'h00001C);
    checkOutput("post_ack", 32'(ackCycle), 32'd21);
    checkOutput("post_dat", wb_mem_dat_o, 32'hF0DEBC9A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
